// File: rtl/seq_pattern_tx.sv
// Bit-serial pattern transmitter: sends a latched PAT_W-bit pattern MSB-first, with repeat count and idle gap.
// Define SEQ_PATTERN_TX_PARITY_EN to append an even-parity bit to every frame.
module seq_pattern_tx #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [CNT_W-1:0] repeat_i,
  input  logic [GAP_W-1:0] gap_i,
  output logic             seq_out_o,
  output logic             bit_valid_o,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic             done_o
);

`ifdef SEQ_PATTERN_TX_PARITY_EN
  localparam int FRAME_W = PAT_W + 1;
`else
  localparam int FRAME_W = PAT_W;
`endif
  localparam int IDX_W = $clog2(FRAME_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

  // The parity bit rides at the bottom of the shift register so SEND never special-cases it.
  function automatic logic [FRAME_W-1:0] frame_of(input logic [PAT_W-1:0] p);
`ifdef SEQ_PATTERN_TX_PARITY_EN
    return {p, ^p};
`else
    return p;
`endif
  endfunction

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]   frames_q, frames_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [GAP_W-1:0]   gcnt_q, gcnt_d;
  logic [IDX_W-1:0]   bidx_q, bidx_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pat_q    <= '0;
      shreg_q  <= '0;
      frames_q <= '0;
      gap_q    <= '0;
      gcnt_q   <= '0;
      bidx_q   <= '0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      shreg_q  <= shreg_d;
      frames_q <= frames_d;
      gap_q    <= gap_d;
      gcnt_q   <= gcnt_d;
      bidx_q   <= bidx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    shreg_d  = shreg_q;
    frames_d = frames_q;
    gap_d    = gap_q;
    gcnt_d   = gcnt_q;
    bidx_d   = bidx_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          pat_d    = pattern_i;
          shreg_d  = frame_of(pattern_i);
          frames_d = (repeat_i == '0) ? CNT_W'(1) : repeat_i;
          gap_d    = gap_i;
          bidx_d   = LAST_IDX;
          state_d  = SEND;
        end
      end
      SEND: begin
        shreg_d = shreg_q << 1;
        bidx_d  = bidx_q - IDX_W'(1);
        if (bidx_q == '0) begin
          if (frames_q == CNT_W'(1)) begin
            frames_d = '0;
            bidx_d   = '0;
            state_d  = DONE;
          end else if (gap_q == '0) begin
            shreg_d  = frame_of(pat_q);
            bidx_d   = LAST_IDX;
            frames_d = frames_q - CNT_W'(1);
          end else begin
            gcnt_d   = gap_q;
            bidx_d   = '0;
            frames_d = frames_q - CNT_W'(1);
            state_d  = GAP;
          end
        end
      end
      GAP: begin
        if (gcnt_q == GAP_W'(1)) begin
          gcnt_d  = '0;
          shreg_d = frame_of(pat_q);
          bidx_d  = LAST_IDX;
          state_d = SEND;
        end else begin
          gcnt_d = gcnt_q - GAP_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort overrides everything above, including a start accepted in IDLE.
    if (abort_i) begin
      state_d  = IDLE;
      pat_d    = pat_q;
      gap_d    = gap_q;
      shreg_d  = '0;
      frames_d = '0;
      gcnt_d   = '0;
      bidx_d   = '0;
    end
  end

  always_comb begin
    seq_out_o    = (state_q == SEND) && shreg_q[FRAME_W-1];
    bit_valid_o  = (state_q == SEND);
    busy_o       = (state_q == SEND) || (state_q == GAP);
    frame_done_o = (state_q == SEND) && (bidx_q == '0);
    done_o       = (state_q == DONE);
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: expected per-cycle output tuples are queued at issue time and
// popped by a negedge monitor once a transfer is under way; outside transfers all outputs must stay 0.
module tb_seq_pattern_tx;
  localparam int PW = 4;
  localparam int CW = 8;
  localparam int GW = 4;
`ifdef SEQ_PATTERN_TX_PARITY_EN
  localparam int FW = PW + 1;
`else
  localparam int FW = PW;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [PW-1:0] pattern = '0;
  logic [CW-1:0] rep = '0;
  logic [GW-1:0] gap = '0;
  logic          seq_out, bit_valid, busy, frame_done, done;

  int total = 0;
  int bad = 0;
  logic [4:0] sbq[$];
  bit armed = 1'b0;

  seq_pattern_tx #(.PAT_W(PW), .CNT_W(CW), .GAP_W(GW)) dut (
    .clock(clock), .reset(reset), .start_i(start), .abort_i(abort),
    .pattern_i(pattern), .repeat_i(rep), .gap_i(gap),
    .seq_out_o(seq_out), .bit_valid_o(bit_valid), .busy_o(busy),
    .frame_done_o(frame_done), .done_o(done)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] obs();
    return {busy, bit_valid, seq_out, frame_done, done};
  endfunction

  // Tuple order: {busy, bit_valid, seq_out, frame_done, done}
  always @(negedge clock) begin
    if (armed && sbq.size() > 0) chk("stream", obs(), sbq.pop_front());
    else chk("quiet", obs(), 5'b0);
  end

  function automatic void expect_xfer(input logic [PW-1:0] pat, input int r, input int g);
    int frames;
    logic b;
    frames = (r == 0) ? 1 : r;
    for (int f = 0; f < frames; f++) begin
      for (int i = 0; i < FW; i++) begin
        b = (i < PW) ? pat[PW-1-i] : ^pat;
        sbq.push_back({1'b1, 1'b1, b, (i == FW-1), 1'b0});
      end
      if (f < frames - 1)
        for (int k = 0; k < g; k++) sbq.push_back(5'b10000);
    end
    sbq.push_back(5'b00001);
  endfunction

  task automatic issue(input logic [PW-1:0] pat, input int r, input int g,
                       input int hold, input logic [PW-1:0] newpat);
    @(negedge clock);
    pattern = pat;
    rep = CW'(r);
    gap = GW'(g);
    start = 1'b1;
    expect_xfer(pat, r, g);
    @(posedge clock);
    #1;
    armed = 1'b1;
    for (int h = 1; h < hold; h++) begin
      pattern = newpat;
      rep = 8'd3;
      gap = 4'd2;
      @(posedge clock);
      #1;
    end
    start = 1'b0;
    pattern = newpat;
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && sbq.size() > 0; i++) @(negedge clock);
    chk("drain", sbq.size(), 0);
    sbq.delete();
    armed = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  initial begin
    bit seen;
    @(negedge clock);
    chk("reset_state", obs(), 5'b0);
    #2 reset = 1'b0;
    repeat (2) @(negedge clock);

    issue(4'b1000, 1, 0, 1, 4'b0000);  drain();
    issue(4'b1000, 3, 0, 1, 4'b0000);  drain();
    issue(4'b1011, 2, 2, 1, 4'b0000);  drain();
    issue(4'b0110, 0, 0, 1, 4'b0000);  drain();
    // start held for three edges while pattern/repeat/gap change underneath
    issue(4'b1100, 1, 0, 3, 4'b0011);  drain();
    issue(4'b1001, 2, 15, 1, 4'b0000); drain();
    issue(4'b0001, 255, 0, 1, 4'b0000); drain();

    // abort on the 2nd bit of frame 1 of 3
    @(negedge clock);
    pattern = 4'b1011; rep = 8'd3; gap = 4'd0; start = 1'b1;
    sbq.push_back(5'b11100);
    sbq.push_back(5'b11000);
    @(posedge clock); #1; start = 1'b0; armed = 1'b1;
    @(posedge clock); #1; abort = 1'b1;
    @(posedge clock); #1; abort = 1'b0;
    drain();
    issue(4'b1011, 1, 0, 1, 4'b0000); drain();

    // abort beats start in the same cycle
    @(negedge clock);
    pattern = 4'b1111; rep = 8'd1; start = 1'b1; abort = 1'b1;
    @(posedge clock); #1; start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clock);
    chk("abort_over_start", busy, 1'b0);

    // start presented only during the DONE cycle is ignored
    issue(4'b0101, 1, 0, 1, 4'b0000);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clock);
      if (done) seen = 1'b1;
    end
    chk("saw_done", seen, 1'b1);
    start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    drain();

    // reset mid-transfer clears outputs immediately
    @(negedge clock);
    pattern = 4'b1111; rep = 8'd2; gap = 4'd1; start = 1'b1;
    sbq.push_back(5'b11100);
    @(posedge clock); #1; start = 1'b0; armed = 1'b1;
    @(negedge clock);
    #2 reset = 1'b1;
    #1 chk("reset_mid", obs(), 5'b0);
    @(negedge clock);
    #2 reset = 1'b0;
    drain();
    issue(4'b0110, 1, 0, 1, 4'b0000); drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
